mc_sequencer: RTL

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
// Microcode sequencer: steps {IR, MCPC} through a microcode ROM and enters forced
// BRK_OP sequences on reset and interrupts. Define MC_SEQ_NMI_EN to enable the NMI edge latch.
module mc_sequencer #(
  parameter int IR_W   = 8,
  parameter int MCPC_W = 3,
  parameter int BRK_OP = 0
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     RDY,
  input  logic                     NMI,
  input  logic                     IRQ,
  input  logic                     i_flag,
  input  logic                     mc_end,
  input  logic [IR_W-1:0]          d_in,
  output logic [IR_W+MCPC_W-1:0]   mc_addr,
  output logic                     sync,
  output logic [1:0]               int_kind,
  output logic                     mc_ovf,
  output logic                     o_dbg_state
);

  localparam logic [IR_W-1:0]   L_BRK      = IR_W'(BRK_OP);
  localparam logic [MCPC_W-1:0] L_MCPC_MAX = '1;

  localparam logic [1:0] K_NORMAL = 2'b00;
  localparam logic [1:0] K_RESET  = 2'b01;
  localparam logic [1:0] K_NMI    = 2'b10;
  localparam logic [1:0] K_IRQ    = 2'b11;

  typedef enum logic {ST_INT = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t              r_state;
  logic [IR_W-1:0]     r_ir;
  logic [MCPC_W-1:0]   r_mcpc;
  logic [1:0]          r_kind;

  logic w_nmi_pend;
  logic w_irq_pend;
  logic w_mcpc_max;

`ifdef MC_SEQ_NMI_EN
  logic r_nmi_prev;
  logic r_nmi_pend;
  logic w_nmi_edge;
  logic w_nmi_clear;

  // The edge detector runs regardless of RDY; a fresh edge in the clearing cycle re-arms the latch.
  assign w_nmi_edge  = r_nmi_prev & ~NMI;
  assign w_nmi_clear = RDY & mc_end & r_nmi_pend;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_nmi_prev <= NMI;
      r_nmi_pend <= (r_nmi_pend & ~w_nmi_clear) | w_nmi_edge;
    end
  end

  assign w_nmi_pend = r_nmi_pend;
`else
  logic w_unused_nmi;
  assign w_unused_nmi = NMI;
  assign w_nmi_pend   = 1'b0;
`endif

  assign w_irq_pend = ~IRQ & ~i_flag;
  assign w_mcpc_max = (r_mcpc == L_MCPC_MAX);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_INT;
      r_ir    <= L_BRK;
      r_mcpc  <= '0;
      r_kind  <= K_RESET;
    end else if (RDY) begin
      if (mc_end) begin
        r_mcpc <= '0;
        if (w_nmi_pend) begin
          r_ir    <= L_BRK;
          r_state <= ST_INT;
          r_kind  <= K_NMI;
        end else if (w_irq_pend) begin
          r_ir    <= L_BRK;
          r_state <= ST_INT;
          r_kind  <= K_IRQ;
        end else begin
          r_ir    <= d_in;
          r_state <= ST_EXEC;
          r_kind  <= K_NORMAL;
        end
      end else if (w_mcpc_max) begin
        // Runaway row without mc_end: force a fresh fetch, never an interrupt entry.
        r_mcpc  <= '0;
        r_ir    <= d_in;
        r_state <= ST_EXEC;
        r_kind  <= K_NORMAL;
      end else begin
        r_mcpc <= r_mcpc + 1'b1;
      end
    end
  end

  assign mc_addr     = {r_ir, r_mcpc};
  assign sync        = mc_end;
  assign int_kind    = r_kind;
  assign mc_ovf      = RDY & ~mc_end & w_mcpc_max;
  assign o_dbg_state = (r_state == ST_EXEC);

endmodule
